// File: rtl/fc_layer_par.sv
// fc_layer_par: fully-connected layer y = act(sat(W*x + b)) with P parallel MAC lanes.
//
// Ports:
//   clk, reset         clock; asynchronous active-low reset
//   s_valid/s_ready    input stream of x elements (data_in), one per accepted beat
//   m_valid/m_ready    output stream of y elements (data_out), y[0] first
//   w_wr_en/w_addr/w_data  weight write port, row-major index row*N+col
//   b_wr_en/b_addr/b_data  bias write port
//   state_dbg          current FSM state (0 LOAD, 1 MAC, 2 OUT)
//
// Handshake: a word moves on a rising edge where valid && ready are both high.
// While m_valid is high and m_ready low, data_out and m_valid hold steady.
module fc_layer_par #(
  parameter int M    = 6,
  parameter int N    = 8,
  parameter int T    = 16,
  parameter int P    = 2,
  parameter int F    = 0,
  parameter int RELU = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [T-1:0]          data_in,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic signed [T-1:0]          data_out,
  input  logic                         w_wr_en,
  input  logic [$clog2(M*N)-1:0]       w_addr,
  input  logic signed [T-1:0]          w_data,
  input  logic                         b_wr_en,
  input  logic [$clog2(M)-1:0]         b_addr,
  input  logic signed [T-1:0]          b_data,
  output logic [1:0]                   state_dbg
);

  localparam int G  = M / P;
  localparam int WA = $clog2(M*N);
  localparam int BA = $clog2(M);
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  // Wide enough that N products plus a bias never overflow.
  localparam int AW = 2*T + $clog2(N+1) + F;

  localparam logic signed [AW-1:0] SAT_MAX = AW'((64'sd1 <<< (T-1)) - 64'sd1);
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [T-1:0]  MAX_T   = {1'b0, {(T-1){1'b1}}};
  localparam logic signed [T-1:0]  MIN_T   = {1'b1, {(T-1){1'b0}}};

  typedef enum logic [1:0] {S_LOAD = 2'd0, S_MAC = 2'd1, S_OUT = 2'd2} state_t;

  state_t state_q, state_d;

  logic [KW-1:0] in_cnt, k_cnt;
  logic [GW-1:0] g_cnt;
  logic [BA-1:0] out_cnt;
  logic          rdy_q;

  logic signed [T-1:0] w_mem [M*N];
  logic signed [T-1:0] b_mem [M];
  logic signed [T-1:0] x_mem [N];
  logic signed [T-1:0] ybuf  [M];

  logic signed [T-1:0] y_lane   [P];
  logic [BA-1:0]       row_lane [P];

  logic k_last, g_last, in_last, out_last;

  assign k_last   = (k_cnt == KW'(N-1));
  assign g_last   = (g_cnt == GW'(G-1));
  assign in_last  = (in_cnt == KW'(N-1));
  assign out_last = (out_cnt == BA'(M-1));

  // ---------------------------------------------------------------- lanes
  for (genvar p = 0; p < P; p++) begin : g_lane
    logic [BA-1:0]        row;
    logic [WA-1:0]        widx;
    logic signed [2*T-1:0] prod;
    logic signed [AW-1:0] base, sum, shifted, acc_q;
    logic signed [T-1:0]  sat, y;

    assign row  = BA'(int'(g_cnt) * P + p);
    assign widx = WA'(int'(row) * N + int'(k_cnt));
    assign prod = w_mem[widx] * x_mem[k_cnt];
    // First column of a group restarts the accumulation from the scaled bias.
    assign base    = (k_cnt == '0) ? (AW'(b_mem[row]) <<< F) : acc_q;
    assign sum     = base + AW'(prod);
    assign shifted = sum >>> F;

    always_comb begin
      sat = shifted[T-1:0];
      if (shifted > SAT_MAX)      sat = MAX_T;
      else if (shifted < SAT_MIN) sat = MIN_T;
      y = ((RELU != 0) && sat[T-1]) ? '0 : sat;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)               acc_q <= '0;
      else if (state_q == S_MAC) acc_q <= sum;
    end

    assign y_lane[p]   = y;
    assign row_lane[p] = row;
  end

  // ---------------------------------------------------------------- storage (not reset)
  always_ff @(posedge clk) begin
    if (w_wr_en && (int'(w_addr) < M*N)) w_mem[w_addr] <= w_data;
    if (b_wr_en && (int'(b_addr) < M))   b_mem[b_addr] <= b_data;
    if (state_q == S_LOAD && s_valid && s_ready) x_mem[in_cnt] <= data_in;
    if (state_q == S_MAC && k_last) begin
      for (int p = 0; p < P; p++) ybuf[row_lane[p]] <= y_lane[p];
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_LOAD;
    else        state_q <= state_d;
  end

  // Holds s_ready low through reset and until the first edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdy_q <= 1'b0;
    else        rdy_q <= 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    data_out  = '0;
    state_dbg = state_q;
    case (state_q)
      S_LOAD: begin
        s_ready = rdy_q;
        if (s_valid && rdy_q && in_last) state_d = S_MAC;
      end
      S_MAC: begin
        if (k_last && g_last) state_d = S_OUT;
      end
      S_OUT: begin
        m_valid  = 1'b1;
        data_out = ybuf[out_cnt];
        if (m_ready && out_last) state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_cnt  <= '0;
      k_cnt   <= '0;
      g_cnt   <= '0;
      out_cnt <= '0;
    end else begin
      case (state_q)
        S_LOAD: if (s_valid && s_ready) in_cnt <= in_last ? '0 : in_cnt + 1'b1;
        S_MAC: begin
          if (k_last) begin
            k_cnt <= '0;
            g_cnt <= g_last ? '0 : g_cnt + 1'b1;
          end else begin
            k_cnt <= k_cnt + 1'b1;
          end
        end
        S_OUT: if (m_ready) out_cnt <= out_last ? '0 : out_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_par.sv
// Bench for fc_layer_par: two instances (RELU=1 and RELU=0) share all inputs;
// expected outputs come from a plain-arithmetic matrix-vector model.
module tb_fc_layer_par;
  localparam int M = 4, N = 3, P = 2, T = 16, F = 0;
  localparam int WA = $clog2(M*N), BA = $clog2(M);

  // ---------------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic                s_valid, m_ready, w_wr_en, b_wr_en;
  logic signed [T-1:0] data_in, w_data, b_data;
  logic [WA-1:0]       w_addr;
  logic [BA-1:0]       b_addr;
  logic                s_ready_r, s_ready_l, m_valid_r, m_valid_l;
  logic signed [T-1:0] data_out_r, data_out_l;
  logic [1:0]          st_r, st_l;

  fc_layer_par #(.M(M), .N(N), .T(T), .P(P), .F(F), .RELU(1)) dut_r (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_r), .data_in(data_in),
    .m_valid(m_valid_r), .m_ready(m_ready), .data_out(data_out_r),
    .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data),
    .b_wr_en(b_wr_en), .b_addr(b_addr), .b_data(b_data), .state_dbg(st_r));

  fc_layer_par #(.M(M), .N(N), .T(T), .P(P), .F(F), .RELU(0)) dut_l (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_l), .data_in(data_in),
    .m_valid(m_valid_l), .m_ready(m_ready), .data_out(data_out_l),
    .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data),
    .b_wr_en(b_wr_en), .b_addr(b_addr), .b_data(b_data), .state_dbg(st_l));

  longint cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [T-1:0] exp_r_q[$];
  logic [T-1:0] exp_l_q[$];
  int wm[M*N];
  int bm[M];

  bit rand_ready = 1'b0;
  bit ready_val  = 1'b1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  function automatic logic [T-1:0] model_y(input int i, input bit relu, input int xv[N]);
    longint s;
    s = longint'(bm[i]) * (longint'(1) << F);
    for (int k = 0; k < N; k++) s += longint'(wm[i*N + k]) * longint'(xv[k]);
    s = s >>> F;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return T'(s);
  endfunction

  // ---------------------------------------------------------------- downstream ready
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  // ---------------------------------------------------------------- monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      if (m_valid_r && m_ready) begin
        if (exp_r_q.size() == 0) check("relu_out_unexpected", longint'(data_out_r), -99999);
        else check("relu_out", longint'(data_out_r), longint'($signed(exp_r_q.pop_front())));
      end
      if (m_valid_l && m_ready) begin
        if (exp_l_q.size() == 0) check("lin_out_unexpected", longint'(data_out_l), -99999);
        else check("lin_out", longint'(data_out_l), longint'($signed(exp_l_q.pop_front())));
      end
      if (!m_valid_r) check("relu_idle_zero", longint'(data_out_r), 0);
      if (!m_valid_l) check("lin_idle_zero", longint'(data_out_l), 0);
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_w(input int a, input int v);
    w_wr_en = 1'b1; w_addr = WA'(a); w_data = T'(v);
    tick();
    w_wr_en = 1'b0;
    if (a < M*N) wm[a] = v;
  endtask

  task automatic wr_b(input int a, input int v);
    b_wr_en = 1'b1; b_addr = BA'(a); b_data = T'(v);
    tick();
    b_wr_en = 1'b0;
    if (a < M) bm[a] = v;
  endtask

  task automatic wr_all(input int wv, input int bv);
    for (int a = 0; a < M*N; a++) wr_w(a, wv);
    for (int a = 0; a < M; a++) wr_b(a, bv);
  endtask

  function automatic int rnd_val(input bit full);
    if (full) return int'($urandom_range(0, 65535)) - 32768;
    return int'($urandom_range(0, 16)) - 8;
  endfunction

  task automatic send_vec(input int xv[N], input bit gaps, output longint t_acc);
    int n;
    t_acc = 0;
    for (int k = 0; k < N; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      s_valid = 1'b1;
      data_in = T'(xv[k]);
      n = 0;
      while (!s_ready_r && n < 200) begin tick(); n++; end
      if (n >= 200) begin
        check("s_ready_timeout", 0, 1);
        s_valid = 1'b0;
        return;
      end
      tick();
      t_acc = cyc;
      s_valid = 1'b0;
    end
    for (int i = 0; i < M; i++) begin
      exp_r_q.push_back(model_y(i, 1'b1, xv));
      exp_l_q.push_back(model_y(i, 1'b0, xv));
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_r_q.size() != 0 || exp_l_q.size() != 0) && n < 500) begin tick(); n++; end
    if (n >= 500) check("drain_timeout", exp_r_q.size() + exp_l_q.size(), 0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int xv[N];
    longint t;
    int n, hi;

    reset = 1'b0; s_valid = 1'b0; data_in = '0;
    w_wr_en = 1'b0; w_addr = '0; w_data = '0;
    b_wr_en = 1'b0; b_addr = '0; b_data = '0;
    #1;
    check("rst_s_ready", s_ready_r, 0);
    check("rst_m_valid", m_valid_r, 0);
    check("rst_data_out", longint'(data_out_l), 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    check("rel_s_ready_before_edge", s_ready_r, 0);
    tick();
    check("rel_s_ready_after_edge", s_ready_r, 1);

    // All ones, zero bias, x=(1,2,3): every row sums to 6; also timing.
    wr_all(1, 0);
    xv = '{1, 2, 3};
    send_vec(xv, 1'b0, t);
    n = 0;
    while (!m_valid_r && n < 50) begin tick(); n++; end
    check("first_valid_cycle", cyc, t + 6);
    hi = 0;
    while (m_valid_r && hi < 20) begin hi++; tick(); end
    check("valid_burst_len", hi, M);
    check("ready_return_cycle", cyc, t + 10);
    check("ready_return_level", s_ready_r, 1);
    drain();

    // Row 0 weights -1 with bias 2: relu gives 0, linear gives -4.
    for (int a = 0; a < N; a++) wr_w(a, -1);
    wr_b(0, 2);
    send_vec(xv, 1'b1, t);
    drain();

    // Saturation at both rails; out-of-range weight writes must be dropped.
    wr_all(32767, 0);
    wr_w(M*N, 123);
    wr_w(M*N + 3, -77);
    xv = '{32767, 32767, 32767};
    send_vec(xv, 1'b0, t);
    drain();
    wr_all(-32768, 0);
    send_vec(xv, 1'b0, t);
    drain();

    // Backpressure: hold m_ready low for 5 cycles after the first m_valid.
    for (int a = 0; a < M*N; a++) wr_w(a, rnd_val(1'b0));
    for (int a = 0; a < M; a++) wr_b(a, rnd_val(1'b0));
    ready_val = 1'b0;
    for (int k = 0; k < N; k++) xv[k] = rnd_val(1'b0);
    send_vec(xv, 1'b0, t);
    n = 0;
    while (!m_valid_r && n < 50) begin tick(); n++; end
    for (int c = 0; c < 5; c++) begin
      check("bp_m_valid", m_valid_r, 1);
      check("bp_s_ready", s_ready_r, 0);
      check("bp_hold_y0", longint'(data_out_l), longint'($signed(exp_l_q[0])));
      tick();
    end
    ready_val = 1'b1;
    drain();

    // Randomized vectors and weights with random downstream readiness.
    rand_ready = 1'b1;
    for (int it = 0; it < 10; it++) begin
      drain();
      for (int a = 0; a < M*N; a++) wr_w(a, rnd_val(it[0]));
      for (int a = 0; a < M; a++) wr_b(a, rnd_val(it[0]));
      for (int k = 0; k < N; k++) xv[k] = rnd_val(it[0]);
      send_vec(xv, 1'b1, t);
    end
    drain();
    rand_ready = 1'b0;
    ready_val = 1'b1;

    // Reset pulse mid-MAC: partial result dropped, weights retained.
    wr_all(1, 0);
    for (int k = 0; k < N; k++) xv[k] = rnd_val(1'b0);
    send_vec(xv, 1'b0, t);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    exp_r_q.delete();
    exp_l_q.delete();
    check("mac_rst_m_valid", m_valid_r, 0);
    check("mac_rst_s_ready", s_ready_r, 0);
    check("mac_rst_data_out", longint'(data_out_r), 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("mac_rel_s_ready", s_ready_r, 1);
    repeat (8) begin
      check("mac_rel_no_valid", m_valid_r, 0);
      tick();
    end
    xv = '{1, 2, 3};
    send_vec(xv, 1'b0, t);
    drain();

    repeat (3) tick();
    check("final_queue_empty", exp_r_q.size() + exp_l_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
